// File: rtl/rv_opsel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_opsel_pkg
// Description : Shared definitions for the ID->EX operand-A select path:
//               the operand select encoding, default widths and PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_opsel_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_ZERO = 2'b10,
        OPA_PC4  = 2'b11
    } opa_sel_e;

endpackage : rv_opsel_pkg
`default_nettype wire

// File: rtl/fwd_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_prio_sel
// Description : Priority match of rs1 against NUM_FWD forwarding sources.
//               Source 0 is the youngest and wins over older sources.
//               x0 never matches.
// Ports       : i_rs1_addr    - register index being read
//               i_fwd_valid   - per-source "holds a register write"
//               i_fwd_pending - per-source "result not yet available"
//               i_fwd_rd      - packed destination indices
//               i_fwd_data    - packed result data
//               o_hit         - some source matched
//               o_pending     - the winning source is still pending
//               o_data        - data of the winning source
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_prio_sel
    import rv_opsel_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_FWD = 2
) (
    input  logic [REG_AW-1:0]         i_rs1_addr,
    input  logic [NUM_FWD-1:0]        i_fwd_valid,
    input  logic [NUM_FWD-1:0]        i_fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
    output logic                      o_hit,
    output logic                      o_pending,
    output logic [XLEN-1:0]           o_data
);

    logic [NUM_FWD-1:0] w_match;

    genvar g;
    generate
        for (g = 0; g < NUM_FWD; g++) begin : g_match
            assign w_match[g] = i_fwd_valid[g]
                             && (i_fwd_rd[g*REG_AW +: REG_AW] == i_rs1_addr)
                             && (i_rs1_addr != '0);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index is the
    // last writer and therefore wins.
    always_comb begin
        o_hit     = 1'b0;
        o_pending = 1'b0;
        o_data    = '0;
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (w_match[s]) begin
                o_hit     = 1'b1;
                o_pending = i_fwd_pending[s];
                o_data    = i_fwd_data[s*XLEN +: XLEN];
            end
        end
    end

endmodule : fwd_prio_sel
`default_nettype wire

// File: rtl/opa_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : opa_fwd_stage
// Description : Operand-A path at the ID->EX boundary. Selects rs1 / PC /
//               zero / PC+4, forwards rs1 from younger stages, stalls on
//               pending (load) results and registers the operand into a
//               valid/ready slot feeding the ALU.
// Ports       : i_clk, i_rst_n  - clock, asynchronous active-low reset
//               i_flush         - kill output slot and current input
//               i_valid/o_ready - ID-side request handshake
//               i_opa_sel       - 00 rs1, 01 pc, 10 zero, 11 pc+4
//               i_rs1_addr/data - rs1 index and register-file data
//               i_pc            - instruction PC
//               i_fwd_*         - packed forwarding sources, 0 = youngest
//               o_valid/i_ready - EX-side slot handshake
//               o_opa           - registered operand A
//               o_fwd_hit       - operand came from a forwarding source
//               o_stall_cnt     - saturating load-use stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module opa_fwd_stage
    import rv_opsel_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [1:0]                i_opa_sel,
    input  logic [REG_AW-1:0]         i_rs1_addr,
    input  logic [XLEN-1:0]           i_rs1_data,
    input  logic [XLEN-1:0]           i_pc,
    input  logic [NUM_FWD-1:0]        i_fwd_valid,
    input  logic [NUM_FWD-1:0]        i_fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [XLEN-1:0]           o_opa,
    output logic                      o_fwd_hit,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    localparam logic [XLEN-1:0]  c_pc_inc  = XLEN'(PC_INC);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             w_fwd_hit;
    logic             w_fwd_pending;
    logic [XLEN-1:0]  w_fwd_data;
    logic             w_sel_rs1;
    logic             w_hazard;
    logic             w_accept;
    logic [XLEN-1:0]  w_opa;

    // Slot state: r_valid is the EMPTY(0)/FULL(1) state bit.
    logic             r_valid;
    logic [XLEN-1:0]  r_opa;
    logic             r_fwd_hit;
    logic [CNT_W-1:0] r_stall_cnt;

    fwd_prio_sel #(
        .XLEN    (XLEN),
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_prio_sel (
        .i_rs1_addr    (i_rs1_addr),
        .i_fwd_valid   (i_fwd_valid),
        .i_fwd_pending (i_fwd_pending),
        .i_fwd_rd      (i_fwd_rd),
        .i_fwd_data    (i_fwd_data),
        .o_hit         (w_fwd_hit),
        .o_pending     (w_fwd_pending),
        .o_data        (w_fwd_data)
    );

    assign w_sel_rs1 = (opa_sel_e'(i_opa_sel) == OPA_RS1);

    // Only the winning source's pending flag matters: an older pending
    // source shadowed by a younger ready one does not stall.
    assign w_hazard = w_sel_rs1 && w_fwd_hit && w_fwd_pending;

    assign o_ready  = (!r_valid || i_ready) && !w_hazard && !i_flush;
    assign w_accept = i_valid && o_ready;

    always_comb begin
        w_opa = '0;
        case (opa_sel_e'(i_opa_sel))
            OPA_RS1: begin
                if (w_fwd_hit)
                    w_opa = w_fwd_data;
                else if (i_rs1_addr == '0)
                    w_opa = '0;
                else
                    w_opa = i_rs1_data;
            end
            OPA_PC:   w_opa = i_pc;
            OPA_ZERO: w_opa = '0;
            OPA_PC4:  w_opa = i_pc + c_pc_inc;
            default:  w_opa = '0;
        endcase
    end

    // Slot register. Flush dominates; otherwise an accept (re)fills the
    // slot, and a consume without accept drains it. Data/hit hold while
    // the slot is full and not consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_opa     <= '0;
            r_fwd_hit <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_opa     <= w_opa;
            r_fwd_hit <= w_sel_rs1 && w_fwd_hit;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    // Load-use stall counter, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_valid && w_hazard && !i_flush
                     && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_valid     = r_valid;
    assign o_opa       = r_opa;
    assign o_fwd_hit   = r_fwd_hit;
    assign o_stall_cnt = r_stall_cnt;

endmodule : opa_fwd_stage
`default_nettype wire

// File: tb/tb_opa_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_opa_fwd_stage
// Description : Self-checking bench for opa_fwd_stage. Directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opa_fwd_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 16;

    logic                      clk;
    logic                      rst_n;
    logic                      flush;
    logic                      valid;
    logic                      rdy_out;
    logic [1:0]                sel;
    logic [REG_AW-1:0]         rs1;
    logic [XLEN-1:0]           rf;
    logic [XLEN-1:0]           pc;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_pending;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      vld_out;
    logic                      ready;
    logic [XLEN-1:0]           opa;
    logic                      hit;
    logic [CNT_W-1:0]          cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the visible state
    logic             m_valid;
    logic [XLEN-1:0]  m_opa;
    logic             m_hit;
    logic [CNT_W-1:0] m_cnt;

    opa_fwd_stage #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_valid       (valid),
        .o_ready       (rdy_out),
        .i_opa_sel     (sel),
        .i_rs1_addr    (rs1),
        .i_rs1_data    (rf),
        .i_pc          (pc),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_pending (fwd_pending),
        .i_fwd_rd      (fwd_rd),
        .i_fwd_data    (fwd_data),
        .o_valid       (vld_out),
        .i_ready       (ready),
        .o_opa         (opa),
        .o_fwd_hit     (hit),
        .o_stall_cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operand, forward-hit and hazard from the current inputs.
    function automatic void ref_eval(output logic [XLEN-1:0] e_opa,
                                     output logic e_hit, output logic e_haz);
        int win;
        win   = -1;
        e_opa = '0;
        e_hit = 1'b0;
        e_haz = 1'b0;
        for (int s = 0; s < NUM_FWD; s++)
            if (win < 0 && fwd_valid[s] && rs1 != 0
                && fwd_rd[s*REG_AW +: REG_AW] == rs1)
                win = s;
        case (sel)
            2'd0: begin
                if (win >= 0) begin
                    e_opa = fwd_data[win*XLEN +: XLEN];
                    e_hit = 1'b1;
                    e_haz = fwd_pending[win];
                end else begin
                    e_opa = (rs1 == 0) ? '0 : rf;
                end
            end
            2'd1:    e_opa = pc;
            2'd2:    e_opa = '0;
            default: e_opa = pc + 32'd4;
        endcase
    endfunction

    function automatic logic exp_ready();
        logic [XLEN-1:0] o;
        logic h, z;
        ref_eval(o, h, z);
        return (!m_valid || ready) && !z && !flush;
    endfunction

    // Advance one clock and update the model from pre-edge inputs.
    task automatic step();
        logic [XLEN-1:0] e_opa;
        logic e_hit, e_haz, e_rdy;
        ref_eval(e_opa, e_hit, e_haz);
        e_rdy = (!m_valid || ready) && !e_haz && !flush;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (valid && e_rdy) begin
            m_valid = 1'b1;
            m_opa   = e_opa;
            m_hit   = e_hit;
        end else if (ready) begin
            m_valid = 1'b0;
        end
        if (valid && e_haz && !flush && m_cnt != {CNT_W{1'b1}})
            m_cnt = m_cnt + 1'b1;
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_opa   = '0;
        m_hit   = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic set_src(input int s, input logic v, input logic p,
                           input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        fwd_valid[s]                = v;
        fwd_pending[s]              = p;
        fwd_rd[s*REG_AW +: REG_AW]  = rd;
        fwd_data[s*XLEN +: XLEN]    = d;
    endtask

    task automatic idle_inputs();
        flush = 0; valid = 0; sel = 2'd0; rs1 = '0; rf = '0; pc = '0;
        fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", vld_out); end
        n_checks++; if (opa !== '0) begin n_fail++; $display("FAIL reset_opa got=%h exp=0", opa); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b exp=0", hit); end
        n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sel_pc();
        valid = 1; sel = 2'd1; pc = 32'h1000; ready = 1;
        #1;
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL pc_ready got=%b exp=1", rdy_out); end
        step();
        n_checks++; if (vld_out !== 1'b1) begin n_fail++; $display("FAIL pc_valid got=%b exp=1", vld_out); end
        n_checks++; if (opa !== 32'h0000_1000) begin n_fail++; $display("FAIL pc_opa got=%h exp=00001000", opa); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL pc_hit got=%b exp=0", hit); end
    endtask

    task automatic test_pc4_wrap();
        valid = 1; sel = 2'd3; pc = 32'hFFFF_FFFC;
        step();
        n_checks++; if (opa !== 32'h0) begin n_fail++; $display("FAIL pc4_wrap got=%h exp=00000000", opa); end
        pc = 32'h0000_0100;
        step();
        n_checks++; if (opa !== 32'h104) begin n_fail++; $display("FAIL pc4 got=%h exp=00000104", opa); end
        sel = 2'd2; pc = 32'hDEAD_BEEF;
        step();
        n_checks++; if (opa !== 32'h0) begin n_fail++; $display("FAIL zero_sel got=%h exp=0", opa); end
    endtask

    task automatic test_fwd_prio();
        valid = 1; sel = 2'd0; rs1 = 5; rf = 32'h11;
        set_src(0, 1, 0, 5, 32'hAA);
        set_src(1, 1, 0, 5, 32'hBB);
        step();
        n_checks++; if (opa !== 32'hAA) begin n_fail++; $display("FAIL fwd_prio_opa got=%h exp=000000aa", opa); end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL fwd_prio_hit got=%b exp=1", hit); end
        // Only the older source matches
        set_src(0, 1, 0, 6, 32'hAA);
        step();
        n_checks++; if (opa !== 32'hBB) begin n_fail++; $display("FAIL fwd_old_opa got=%h exp=000000bb", opa); end
        // Shadowed pending: src1 pending, src0 ready, both match -> no stall
        set_src(0, 1, 0, 5, 32'hAA);
        set_src(1, 1, 1, 5, 32'hBB);
        #1;
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL shadow_ready got=%b exp=1", rdy_out); end
        step();
        set_src(1, 1, 0, 5, 32'hBB);
        rs1 = 0;
        step();
        n_checks++; if (opa !== 32'h0) begin n_fail++; $display("FAIL x0_opa got=%h exp=0", opa); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL x0_hit got=%b exp=0", hit); end
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] c0;
        c0 = cnt;
        valid = 1; sel = 2'd0; rs1 = 7; rf = 32'h77;
        set_src(0, 1, 1, 7, 32'h0);
        set_src(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL lu_ready[%0d] got=%b exp=0", i, rdy_out); end
            step();
        end
        n_checks++; if (cnt !== c0 + 2) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=%0d", cnt, c0 + 2); end
        set_src(0, 1, 0, 7, 32'h55);
        #1;
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL lu_release got=%b exp=1", rdy_out); end
        step();
        n_checks++; if (opa !== 32'h55 || hit !== 1'b1) begin n_fail++; $display("FAIL lu_opa got=%h/%b exp=00000055/1", opa, hit); end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0;
        fwd_valid = '0; fwd_pending = '0;
        valid = 1; sel = 2'd0; rs1 = 3; rf = 32'h10; ready = 1;
        step();
        n_checks++; if (opa !== 32'h10) begin n_fail++; $display("FAIL bp_load got=%h exp=00000010", opa); end
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'd1; pc = $urandom(); rf = $urandom();
            #1;
            n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, rdy_out); end
            step();
            n_checks++; if (vld_out !== 1'b1 || opa !== 32'h10) begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/00000010", i, vld_out, opa); end
        end
        ready = 1; sel = 2'd1; pc = 32'h2000;
        #1;
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", rdy_out); end
        step();
        n_checks++; if (vld_out !== 1'b1 || opa !== 32'h2000) begin n_fail++; $display("FAIL b2b_load got=%b/%h exp=1/00002000", vld_out, opa); end
        // Flush with a concurrent hazardous request: dropped, counter frozen
        c0 = cnt;
        flush = 1; sel = 2'd0; rs1 = 9;
        set_src(0, 1, 1, 9, 32'h99);
        #1;
        n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", rdy_out); end
        step();
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", vld_out); end
        n_checks++; if (cnt !== c0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", cnt, c0); end
        flush = 0; valid = 0; fwd_valid = '0; fwd_pending = '0;
        step();
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL flush_drop got=%b exp=0", vld_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid       = ($urandom_range(0, 3) != 0);
            sel         = 2'($urandom_range(0, 3));
            rs1         = REG_AW'($urandom_range(0, 7));
            rf          = $urandom();
            pc          = $urandom();
            ready       = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 19) == 0);
            for (int s = 0; s < NUM_FWD; s++)
                set_src(s, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        REG_AW'($urandom_range(0, 7)), $urandom());
            #1;
            n_checks++; if (rdy_out !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, rdy_out, exp_ready()); end
            step();
            n_checks++; if (vld_out !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, vld_out, m_valid); end
            if (m_valid) begin
                n_checks++; if (opa !== m_opa) begin n_fail++; $display("FAIL rnd_opa[%0d] got=%h exp=%h", i, opa, m_opa); end
                n_checks++; if (hit !== m_hit) begin n_fail++; $display("FAIL rnd_hit[%0d] got=%b exp=%b", i, hit, m_hit); end
            end
            n_checks++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, cnt, m_cnt); end
        end
    endtask

    task automatic test_async_reset();
        flush = 0; valid = 1; sel = 2'd0; rs1 = 4; ready = 0;
        fwd_valid = '0; fwd_pending = '0;
        set_src(0, 1, 1, 4, 32'h44);
        step();
        step();
        fwd_pending = '0; fwd_valid = '0; sel = 2'd1; pc = 32'h3000;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", vld_out); end
        n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL arst_cnt got=%0d exp=0", cnt); end
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL arst_after got=%b exp=0", vld_out); end
    endtask

    initial begin
        test_reset();
        test_sel_pc();
        test_pc4_wrap();
        test_fwd_prio();
        test_load_use();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_opa_fwd_stage
`default_nettype wire
